// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM with clear sweep.
package ram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Widest word the byte-mask helper supports; callers cast down to their width.
    localparam int unsigned MAX_DATA_W = 1024;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] be_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAX_BE_W); i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read output register chain: RD_LAT stages of data/valid, data holds when no read passes.
module ram_rd_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] data_q  [RD_LAT];
    logic              valid_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rd_valid = valid_q[RD_LAT-1];
    assign dout     = data_q[RD_LAT-1];

endmodule

// File: rtl/ram_sp_sweep.sv
// Single-port RAM with byte-enable writes, valid/ready requests, 1/2-cycle reads
// and a one-word-per-cycle clear sweep started by reset or clr_req.
module ram_sp_sweep
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_din,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_mask;
    logic              xfer;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    assign req_ready = (state == IDLE) && !clr_req;
    assign xfer      = req_valid && req_ready;
    assign rd_en     = xfer && !req_wr;
    assign wr_mask   = DATA_W'(be_mask(MAX_BE_W'(req_be)));
    assign rd_word   = mem[req_addr];

    // Sweep/idle controller; the counter is one bit wider so the terminal compare is explicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= SWEEP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= SWEEP;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array is not reset; sweep writes and user writes never coincide since req_ready is low in SWEEP.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[cnt[ADDR_W-1:0]] <= CLR_VAL;
        end else if (xfer && req_wr) begin
            mem[req_addr] <= (mem[req_addr] & ~wr_mask) | (req_din & wr_mask);
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_en),
        .in_data  (rd_word),
        .rd_valid (rd_valid),
        .dout     (dout)
    );

endmodule

// File: tb/tb_ram_sp_sweep.sv
// Directed bench for ram_sp_sweep: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus.
module tb_ram_sp_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_din;
    logic        clr_req;

    logic        ready1, busy1, rv1;
    logic [15:0] dout1;
    logic        ready2, busy2, rv2;
    logic [15:0] dout2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_sp_sweep u_dut1 (
        .clk (clk), .rst (rst), .req_valid (req_valid), .req_ready (ready1),
        .req_wr (req_wr), .req_addr (req_addr), .req_be (req_be), .req_din (req_din),
        .clr_req (clr_req), .busy (busy1), .rd_valid (rv1), .dout (dout1)
    );

    ram_sp_sweep #(.RD_LAT(2)) u_dut2 (
        .clk (clk), .rst (rst), .req_valid (req_valid), .req_ready (ready2),
        .req_wr (req_wr), .req_addr (req_addr), .req_be (req_be), .req_din (req_din),
        .clr_req (clr_req), .busy (busy2), .rd_valid (rv2), .dout (dout2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy-high samples until busy falls; optional stray clr_req at sample pulse_at.
    task automatic sweep_len(input string tag, input int pulse_at);
        int n;
        logic ready_seen;
        n = 0;
        ready_seen = 1'b0;
        while (busy1 && n < 1000) begin
            if (ready1 || ready2) ready_seen = 1'b1;
            clr_req = (n == pulse_at);
            n++;
            step();
            clr_req = 1'b0;
        end
        chk({tag, "_len"}, 32'(n), 32'd256);
        chk({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
        chk({tag, "_busy2"}, 32'(busy2), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_din = d; req_be = be;
        step();
        req_valid = 1'b0;
        chk("wr_no_rv1", 32'(rv1), 32'd0);
        step();
        chk("wr_no_rv2", 32'(rv2), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        chk({tag, "_ready"}, 32'(ready1), 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, "_rv1"}, 32'(rv1), 32'd1);
        chk({tag, "_dout1"}, 32'(dout1), 32'(exp));
        chk({tag, "_rv2_early"}, 32'(rv2), 32'd0);
        step();
        chk({tag, "_rv1_pulse"}, 32'(rv1), 32'd0);
        chk({tag, "_rv2"}, 32'(rv2), 32'd1);
        chk({tag, "_dout2"}, 32'(dout2), 32'(exp));
    endtask

    initial begin
        logic [15:0] seq [3];
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_be = '0; req_din = '0; clr_req = 1'b0;
        seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333;

        step(); step();
        chk("rst_busy", 32'(busy1), 32'd1);
        chk("rst_ready", 32'(ready1), 32'd0);
        chk("rst_rv", 32'({rv1, rv2}), 32'd0);
        chk("rst_dout", 32'({dout1, dout2}), 32'd0);

        rst = 1'b0;
        sweep_len("init_sweep", -1);
        do_read("rd00", 8'h00, 16'h0000);
        do_read("rdff", 8'hFF, 16'h0000);

        // Byte-enable merge
        do_write(8'h10, 16'hA5C3, 2'b11);
        do_write(8'h10, 16'h00FF, 2'b01);
        do_read("rd10", 8'h10, 16'hA5FF);
        do_write(8'h11, 16'h7777, 2'b11);
        chk("hold_dout1", 32'(dout1), 32'h0000A5FF);
        chk("hold_dout2", 32'(dout2), 32'h0000A5FF);

        // Back-to-back reads
        do_write(8'h01, 16'h1111, 2'b11);
        do_write(8'h02, 16'h2222, 2'b11);
        do_write(8'h03, 16'h3333, 2'b11);
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 3); req_wr = 1'b0; req_addr = 8'(k + 1);
            step();
            chk("b2b_rv1", 32'(rv1), 32'(k < 3));
            if (k < 3) chk("b2b_dout1", 32'(dout1), 32'(seq[k]));
            chk("b2b_rv2", 32'(rv2), 32'(k >= 1 && k < 4));
            if (k >= 1 && k < 4) chk("b2b_dout2", 32'(dout2), 32'(seq[k-1]));
        end
        req_valid = 1'b0;

        // be=0 is a no-op
        do_write(8'h20, 16'h1234, 2'b11);
        do_write(8'h20, 16'hFFFF, 2'b00);
        do_read("rd20", 8'h20, 16'h1234);

        // Read in flight when a sweep starts; clr_req beats a simultaneous request
        do_write(8'h40, 16'hCAFE, 2'b11);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h40;
        step();
        req_wr = 1'b1; req_addr = 8'h30; req_din = 16'hBEEF; req_be = 2'b11; clr_req = 1'b1;
        #1;
        chk("clr_ready", 32'(ready1), 32'd0);
        step();
        req_valid = 1'b0; clr_req = 1'b0;
        chk("clr_busy", 32'(busy1), 32'd1);
        chk("inflight_rv2", 32'(rv2), 32'd1);
        chk("inflight_dout2", 32'(dout2), 32'h0000CAFE);
        sweep_len("clr_sweep", 50);
        do_read("rd10_clr", 8'h10, 16'h0000);
        do_read("rd30_clr", 8'h30, 16'h0000);
        do_read("rd40_clr", 8'h40, 16'h0000);

        // Reset with a read in flight
        do_write(8'h50, 16'hBEEF, 2'b11);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h50;
        step();
        req_valid = 1'b0;
        chk("pre_rst_dout1", 32'(dout1), 32'h0000BEEF);
        rst = 1'b1;
        #1;
        chk("async_rst_dout", 32'({dout1, dout2}), 32'd0);
        chk("async_rst_busy", 32'(busy1), 32'd1);
        chk("async_rst_ready", 32'(ready1), 32'd0);
        step();
        chk("rst_drop_rv", 32'({rv1, rv2}), 32'd0);
        rst = 1'b0;

        // Reset again at sweep address 100
        for (int i = 0; i < 100; i++) step();
        chk("mid_sweep_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_len("rst_sweep", -1);
        do_read("rd50_rst", 8'h50, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_sp_sweep.md
Name: ram_sp_sweep

Overview:
Parametrised single-port synchronous RAM, the successor of the fixed 256x16 scratch RAM. It adds configurable width and depth, byte-enable writes, and a valid/ready request handshake. It adds a selectable 1- or 2-cycle read latency with a data-valid strobe. The whole-array clear now runs as a hardware sweep of one word per cycle, started by reset or by a clear request, instead of a single-cycle clear.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles from accepted request to rd_valid; legal values are 1 and 2
CLR_VAL, 0, DATA_W-bit value written to every word by a sweep

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_be  input  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]
req_din  input  DATA_W  write data
clr_req  input  1  one-cycle pulse that starts a sweep
busy  output  1  a sweep is in progress
rd_valid  output  1  dout holds read data this cycle
dout  output  DATA_W  read data

Behaviour:
- Reset values (asserted asynchronously): busy=1, req_ready=0, rd_valid=0, dout=0, sweep counter=0, FSM=SWEEP, read pipeline valid bits=0. The memory array itself is not reset.
- FSM states: SWEEP and IDLE.
  - In SWEEP: one word per cycle, mem[cnt] <= CLR_VAL and cnt increments.
  - When cnt = DEPTH-1 is written, the FSM goes to IDLE on the next edge and busy falls. A sweep therefore takes exactly DEPTH cycles.
  - In IDLE: clr_req=1 sets cnt=0, FSM=SWEEP and busy=1 on the next edge.
- req_ready = (FSM==IDLE) && !clr_req. A request and a clr_req in the same cycle: the request is refused and the sweep wins.
- A transfer occurs when req_valid && req_ready.
- Write transfer:
  - Every byte with its enable set is updated at that edge; bytes with enable clear keep their value.
  - be=0 is a legal no-op.
  - No rd_valid is produced.
  - dout holds its previous value (no forced zero).
- Read transfer:
  - RD_LAT=1: dout = mem[addr] and rd_valid=1 at the next edge.
  - RD_LAT=2: one more output register stage, so rd_valid rises 2 edges after acceptance.
  - Back-to-back reads are accepted every cycle, giving one result per cycle, in order.
  - A read that follows a write to the same address returns the new data.
- rd_valid is high for exactly one cycle per read. dout holds its last read value while rd_valid=0, except that reset zeroes it.
- Reads already in flight when a sweep starts still complete with the pre-sweep data. A sweep write never lands in the same cycle as a user access, because req_ready=0.
- Reset during a sweep or a read: all state returns to reset values immediately, in-flight reads are dropped (no rd_valid), and a full sweep restarts from address 0 after rst deasserts.
- clr_req while already in SWEEP is ignored; the sweep does not restart.
- Addresses are full range with no wrap handling needed. The sweep counter is ADDR_W+1 bits wide or uses an explicit terminal compare, so it never wraps silently.

Decomposition:
- Shared package ram_pkg: FSM state enum (SWEEP, IDLE) and a function that returns the byte-mask expansion of req_be to DATA_W bits.
- Sub-module ram_rd_pipe holds the RD_LAT-deep data/valid output register chain. It resets asynchronously via rst and is instantiated once.
- The array and FSM stay in the top module.

Test Plan:
- Reset release with defaults: busy=1 for exactly 256 cycles and req_ready=0 throughout; then read addr 0x00 and 0xFF -> rd_valid after 1 cycle, dout=0x0000 both times.
- Write 0xA5C3 to 0x10 with be=2'b11, then write 0x00FF with be=2'b01, then read 0x10 -> dout=0xA5FF.
- RD_LAT=2: reads of 0x01, 0x02, 0x03 on consecutive cycles (data 0x1111/0x2222/0x3333) -> rd_valid high 2 cycles after each, dout sequence 0x1111, 0x2222, 0x3333 with no gaps.
- clr_req pulse with req_valid=1 in the same cycle -> request not accepted, busy=1 the next cycle for 256 cycles; afterwards read 0x10 -> 0x0000.
- Assert rst for 1 cycle at sweep address 100 with a read in flight -> no rd_valid, dout=0 immediately, sweep restarts at address 0 and takes the full 256 cycles.
- Write with be=0 to 0x20 (holding 0x1234) -> a later read returns 0x1234, and no rd_valid appears for the write itself.
